bcd_mod_counter: RTL and testbench

Parametrised multi-digit BCD counter with a programmable wrap value, up/down direction, parallel load and registered carry/borrow pulses. It replaces chains of single-digit counters in the clock datapath: one instance per seconds, minutes and hours field. The carry output of one instance drives the count enable of the next.

---
 rtl/bcd_mod_counter.sv | 126 ++++++++++++
 tb/tb_bcd_mod_counter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/bcd_mod_counter.sv
// Multi-digit packed-BCD counter with programmable wrap value, up/down counting,
// parallel load and registered carry/borrow/load-error pulses.
module bcd_mod_counter #(
    parameter int                  DIGITS  = 2,
    parameter logic [4*DIGITS-1:0] MAX_BCD = (4*DIGITS)'(8'h59)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  count_en,
    input  logic                  down,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  carry_out,
    output logic                  borrow_out,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("bcd_mod_counter: DIGITS must be 1..8");
    end

    logic [W-1:0]      bcd_reg;
    logic [W-1:0]      bcd_next;
    logic              carry_reg;
    logic              carry_next;
    logic              borrow_reg;
    logic              borrow_next;
    logic              load_err_reg;
    logic              load_err_next;

    logic [W-1:0]      inc_value;
    logic [W-1:0]      dec_value;
    logic [DIGITS-1:0] inc_carry;
    logic [DIGITS-1:0] dec_borrow;
    logic [DIGITS-1:0] load_nibble_ok;

    logic              at_max;
    logic              at_zero;
    logic              load_ok;

    assign inc_carry[0]  = 1'b1;
    assign dec_borrow[0] = 1'b1;

    // Ripple of per-digit increment/decrement; each digit only sees its neighbour's carry.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [3:0] digit;
        assign digit = bcd_reg[gi*4 +: 4];

        assign inc_value[gi*4 +: 4] = !inc_carry[gi]  ? digit :
                                      (digit == 4'd9) ? 4'd0 : digit + 4'd1;
        assign dec_value[gi*4 +: 4] = !dec_borrow[gi] ? digit :
                                      (digit == 4'd0) ? 4'd9 : digit - 4'd1;

        if (gi < DIGITS - 1) begin : g_chain
            assign inc_carry[gi+1]  = inc_carry[gi]  && (digit == 4'd9);
            assign dec_borrow[gi+1] = dec_borrow[gi] && (digit == 4'd0);
        end

        assign load_nibble_ok[gi] = (load_value[gi*4 +: 4] <= 4'd9);

        if (MAX_BCD[gi*4 +: 4] > 4'd9) begin : g_bad_max
            $error("bcd_mod_counter: MAX_BCD has a non-BCD nibble");
        end
    end

    assign at_max  = (bcd_reg == MAX_BCD);
    assign at_zero = (bcd_reg == '0);
    // With every nibble in 0..9, packed-BCD ordering matches plain binary ordering.
    assign load_ok = (&load_nibble_ok) && (load_value <= MAX_BCD);

    always_comb begin
        bcd_next      = bcd_reg;
        carry_next    = 1'b0;
        borrow_next   = 1'b0;
        load_err_next = 1'b0;
        if (clear) begin
            bcd_next = '0;
        end else if (load) begin
            if (load_ok) begin
                bcd_next = load_value;
            end else begin
                load_err_next = 1'b1;
            end
        end else if (count_en) begin
            if (!down) begin
                if (at_max) begin
                    bcd_next   = '0;
                    carry_next = 1'b1;
                end else begin
                    bcd_next = inc_value;
                end
            end else begin
                if (at_zero) begin
                    bcd_next    = MAX_BCD;
                    borrow_next = 1'b1;
                end else begin
                    bcd_next = dec_value;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bcd_reg      <= '0;
            carry_reg    <= 1'b0;
            borrow_reg   <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            bcd_reg      <= bcd_next;
            carry_reg    <= carry_next;
            borrow_reg   <= borrow_next;
            load_err_reg <= load_err_next;
        end
    end

    assign bcd        = bcd_reg;
    assign carry_out  = carry_reg;
    assign borrow_out = borrow_reg;
    assign load_err   = load_err_reg;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench: seconds counter (59), minutes stage fed by its carry, hours counter (23).
module tb_bcd_mod_counter;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       clear, load, count_en, down;
    logic [7:0] load_value;
    logic [7:0] bcd;
    logic       carry_out, borrow_out, load_err;

    logic [7:0] m_bcd;
    logic       m_carry, m_borrow, m_err;
    logic       zero_bit = 1'b0;
    logic [7:0] zero_byte = 8'h00;

    logic       h_load, h_count_en;
    logic [7:0] h_load_value;
    logic [7:0] h_bcd;
    logic       h_carry, h_borrow, h_err;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    bcd_mod_counter #(.DIGITS(2), .MAX_BCD(8'h59)) dut (
        .clock(clock), .reset_n(reset_n), .clear(clear), .load(load),
        .load_value(load_value), .count_en(count_en), .down(down),
        .bcd(bcd), .carry_out(carry_out), .borrow_out(borrow_out), .load_err(load_err)
    );

    bcd_mod_counter #(.DIGITS(2), .MAX_BCD(8'h59)) m_dut (
        .clock(clock), .reset_n(reset_n), .clear(zero_bit), .load(zero_bit),
        .load_value(zero_byte), .count_en(carry_out), .down(zero_bit),
        .bcd(m_bcd), .carry_out(m_carry), .borrow_out(m_borrow), .load_err(m_err)
    );

    bcd_mod_counter #(.DIGITS(2), .MAX_BCD(8'h23)) h_dut (
        .clock(clock), .reset_n(reset_n), .clear(zero_bit), .load(h_load),
        .load_value(h_load_value), .count_en(h_count_en), .down(zero_bit),
        .bcd(h_bcd), .carry_out(h_carry), .borrow_out(h_borrow), .load_err(h_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vector %0d %s: observed %0h expected %0h", vectors, tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_bcd,
                           input logic e_c, input logic e_b, input logic e_e);
        check({tag, ".bcd"},    32'(bcd),        32'(e_bcd));
        check({tag, ".carry"},  32'(carry_out),  32'(e_c));
        check({tag, ".borrow"}, 32'(borrow_out), 32'(e_b));
        check({tag, ".lderr"},  32'(load_err),   32'(e_e));
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        logic [7:0] h_exp [5];
        h_exp = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h00};

        reset_n = 1'b0; clear = 1'b0; load = 1'b0; count_en = 1'b0; down = 1'b0;
        load_value = 8'h00; h_load = 1'b0; h_count_en = 1'b0; h_load_value = 8'h00;
        tick(); tick();
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;

        // Async reset in mid-cycle while holding 37
        load = 1'b1; load_value = 8'h37; tick();
        chk_all("load37", 8'h37, 1'b0, 1'b0, 1'b0);
        load = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk_all("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        #1 reset_n = 1'b1;
        count_en = 1'b1;
        tick(); check("resume1", 32'(bcd), 32'h01);
        tick(); check("resume2", 32'(bcd), 32'h02);
        tick(); chk_all("resume3", 8'h03, 1'b0, 1'b0, 1'b0);
        count_en = 1'b0;

        // Up wrap and cascade into minutes
        load = 1'b1; load_value = 8'h58; tick();
        chk_all("load58", 8'h58, 1'b0, 1'b0, 1'b0);
        load = 1'b0; count_en = 1'b1;
        tick(); chk_all("up59", 8'h59, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("wrap00", 8'h00, 1'b1, 1'b0, 1'b0);
        check("min_hold", 32'(m_bcd), 32'h00);
        count_en = 1'b0;
        tick(); chk_all("after_wrap", 8'h00, 1'b0, 1'b0, 1'b0);
        check("min_step1", 32'(m_bcd), 32'h01);

        load = 1'b1; load_value = 8'h09; tick();
        load = 1'b0; count_en = 1'b1;
        tick(); chk_all("up09_10", 8'h10, 1'b0, 1'b0, 1'b0);

        // Down direction
        down = 1'b1;
        tick(); chk_all("dn10_09", 8'h09, 1'b0, 1'b0, 1'b0);
        count_en = 1'b0; clear = 1'b1;
        tick(); chk_all("clear", 8'h00, 1'b0, 1'b0, 1'b0);
        clear = 1'b0; count_en = 1'b1;
        tick(); chk_all("dn_wrap", 8'h59, 1'b0, 1'b1, 1'b0);
        count_en = 1'b0;
        tick(); chk_all("dn_idle", 8'h59, 1'b0, 1'b0, 1'b0);
        down = 1'b0;

        // Load validation
        load = 1'b1; load_value = 8'h4A;
        tick(); chk_all("load4A", 8'h59, 1'b0, 1'b0, 1'b1);
        load_value = 8'h60;
        tick(); chk_all("load60", 8'h59, 1'b0, 1'b0, 1'b1);
        load_value = 8'h45;
        tick(); chk_all("load45", 8'h45, 1'b0, 1'b0, 1'b0);
        load = 1'b0;
        tick(); chk_all("idle45", 8'h45, 1'b0, 1'b0, 1'b0);

        // Priority
        clear = 1'b1; load = 1'b1; load_value = 8'h12; count_en = 1'b1;
        tick(); chk_all("prio_clear", 8'h00, 1'b0, 1'b0, 1'b0);
        clear = 1'b0;
        tick(); chk_all("prio_load", 8'h12, 1'b0, 1'b0, 1'b0);
        load_value = 8'h7A;
        tick(); chk_all("prio_badload", 8'h12, 1'b0, 1'b0, 1'b1);
        load = 1'b0; count_en = 1'b0;
        check("min_still1", 32'(m_bcd), 32'h01);

        // Second cascade wrap
        load = 1'b1; load_value = 8'h59; tick();
        load = 1'b0; count_en = 1'b1;
        tick(); chk_all("wrap2", 8'h00, 1'b1, 1'b0, 1'b0);
        check("min_hold2", 32'(m_bcd), 32'h01);
        count_en = 1'b0;
        tick(); check("min_step2", 32'(m_bcd), 32'h02);
        check("min_carry", 32'(m_carry), 32'h0);

        // Hours configuration
        h_load = 1'b1; h_load_value = 8'h19; tick();
        check("h_load19", 32'(h_bcd), 32'h19);
        h_load = 1'b0; h_count_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("h_step%0d.bcd", i), 32'(h_bcd), 32'(h_exp[i]));
            check($sformatf("h_step%0d.carry", i), 32'(h_carry), (i == 4) ? 32'h1 : 32'h0);
        end
        h_count_en = 1'b0;
        tick(); check("h_idle.carry", 32'(h_carry), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
